// File: rtl/pwm_peripheral.sv
// 16-channel PWM output stage: off / static-on / shared-duty PWM per channel.
// Optional PWM_SYNC_UPDATE_EN: duty updates apply only at the period wrap.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_7_0,
  output logic [7:0] out_15_8,
  output logic       period_start
);

  localparam int unsigned PreW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_DIV - 1);

  logic [PreW-1:0] prescaler_q, prescaler_d;
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;
  logic [7:0]      duty_active_q, duty_active_d;
  logic [15:0]     out_q, out_d;
  logic            period_start_q;
  logic            tick, wrap, pwm_raw;
  logic [15:0]     en_out, en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    tick        = (prescaler_q == PreMax);
    wrap        = tick && (pwm_cnt_q == 8'hFF);
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
`ifdef PWM_SYNC_UPDATE_EN
    duty_active_d = wrap ? pwm_duty_cycle : duty_active_q;
`else
    duty_active_d = pwm_duty_cycle;
`endif
    // 0xFF is forced high so full duty has no dropout at count 0xFF.
    pwm_raw = (duty_active_q == 8'hFF) || (pwm_cnt_q < duty_active_q);
    out_d   = en_out & (~en_pwm | {16{pwm_raw}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q    <= '0;
      pwm_cnt_q      <= 8'h00;
      duty_active_q  <= 8'h00;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_active_q  <= duty_active_d;
      out_q          <= out_d;
      period_start_q <= wrap;
    end
  end

  assign out_7_0      = out_q[7:0];
  assign out_15_8     = out_q[15:8];
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: cycle scoreboard on a CLK_DIV=13 instance plus
// period/duty measurements, and a CLK_DIV=1 instance for the fast-divider case.
module tb_pwm_peripheral;

  localparam int unsigned ClkDiv = 13;
  localparam int unsigned Period = ClkDiv * 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
  logic [7:0] out_lo, out_hi;
  logic       ps;
  logic [7:0] b_en_out_lo, b_en_out_hi, b_en_pwm_lo, b_en_pwm_hi, b_duty;
  logic [7:0] b_out_lo, b_out_hi;
  logic       b_ps;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [16:0] sb_q[$];
  int         m_t = 0;
  logic [7:0] m_duty = 8'h00;

  pwm_peripheral #(.CLK_DIV(ClkDiv)) dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out_lo),
    .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0  (en_pwm_lo),
    .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle  (duty),
    .out_7_0         (out_lo),
    .out_15_8        (out_hi),
    .period_start    (ps)
  );

  pwm_peripheral #(.CLK_DIV(1)) dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (b_en_out_lo),
    .en_reg_out_15_8 (b_en_out_hi),
    .en_reg_pwm_7_0  (b_en_pwm_lo),
    .en_reg_pwm_15_8 (b_en_pwm_hi),
    .pwm_duty_cycle  (b_duty),
    .out_7_0         (b_out_lo),
    .out_15_8        (b_out_hi),
    .period_start    (b_ps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Time-indexed reference: count and prescaler derived from edges since reset.
  task automatic model_push();
    logic [15:0] eo, ep, o;
    logic [7:0]  cnt;
    int          pre;
    logic        wrap, raw;
    if (!rst_n) begin
      m_t    = 0;
      m_duty = 8'h00;
      sb_q.push_back(17'h0);
      return;
    end
    pre  = m_t % ClkDiv;
    cnt  = 8'((m_t / ClkDiv) % 256);
    wrap = (pre == ClkDiv - 1) && (cnt == 8'hFF);
    raw  = (m_duty == 8'hFF) || (cnt < m_duty);
    eo   = {en_out_hi, en_out_lo};
    ep   = {en_pwm_hi, en_pwm_lo};
    for (int i = 0; i < 16; i++) o[i] = eo[i] ? (ep[i] ? raw : 1'b1) : 1'b0;
    sb_q.push_back({o, wrap});
`ifdef PWM_SYNC_UPDATE_EN
    if (wrap) m_duty = duty;
`else
    m_duty = duty;
`endif
    m_t = (m_t + 1) % Period;
  endtask

  task automatic cycle();
    model_push();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else check("sb", 32'({out_hi, out_lo, ps}), 32'(sb_q.pop_front()));
  endtask

  task automatic wait_ps(input string tag);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!ps && n < 4000);
    if (!ps) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic measure(input int chg_at, input logic [7:0] new_duty,
                         output int len, output int highs, output int others);
    len    = 0;
    highs  = 0;
    others = 0;
    do begin
      if (len == chg_at) duty = new_duty;
      cycle();
      len++;
      if (out_lo[0]) highs++;
      if ({out_hi, out_lo[7:1]} != 15'h0) others++;
    end while (!ps && len < 4000);
  endtask

  initial begin
    int len, highs, others, n;
    en_out_lo   = 8'h01;
    en_pwm_lo   = 8'h01;
    en_out_hi   = 8'h00;
    en_pwm_hi   = 8'h00;
    duty        = 8'h80;
    b_en_out_lo = 8'h00;
    b_en_pwm_lo = 8'h00;
    b_en_out_hi = 8'h80;
    b_en_pwm_hi = 8'h80;
    b_duty      = 8'h03;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_lo", 32'(out_lo), 32'h0);
    check("rst_out_hi", 32'(out_hi), 32'h0);
    check("rst_ps", 32'(ps), 32'h0);
    check("rst_cnt", 32'(dut_a.pwm_cnt_q), 32'h0);
    check("rst_b_out", 32'({b_out_hi, b_out_lo, b_ps}), 32'h0);
    rst_n = 1'b1;

    // Duty 0x80 on channel 0: half period high, period_start every Period clks.
    wait_ps("t1_first");
    measure(-1, 8'h00, len, highs, others);
    check("t1_len", 32'(len), 32'(Period));
    check("t1_high", 32'(highs), 32'd1664);
    check("t1_others", 32'(others), 32'd0);

    // Duty 0x00 then 0xFF, one settling period each.
    duty = 8'h00;
    measure(-1, 8'h00, len, highs, others);
    measure(-1, 8'h00, len, highs, others);
    check("t2_zero_high", 32'(highs), 32'd0);
    duty = 8'hFF;
    measure(-1, 8'h00, len, highs, others);
    measure(-1, 8'h00, len, highs, others);
    check("t2_full_len", 32'(len), 32'(Period));
    check("t2_full_high", 32'(highs), 32'(Period));

    // Static enables on upper bank, PWM-only selects with no enables on lower.
    en_out_hi = 8'hA5;
    en_pwm_hi = 8'h00;
    en_out_lo = 8'h00;
    en_pwm_lo = 8'hFF;
    check("t3_before", 32'(out_hi), 32'h0);
    cycle();
    check("t3_hi", 32'(out_hi), 32'hA5);
    check("t3_lo", 32'(out_lo), 32'h0);
    repeat (300) cycle();
    check("t3_hold", 32'({out_hi, out_lo}), 32'hA500);
    en_out_hi = 8'h00;
    en_out_lo = 8'h01;
    en_pwm_lo = 8'h01;

    // Duty 0x40 -> 0xC0 at pwm_cnt = 0x10.
    duty = 8'h40;
    measure(-1, 8'h00, len, highs, others);
    measure(-1, 8'h00, len, highs, others);
    check("t4_base_high", 32'(highs), 32'd832);
    measure(16 * ClkDiv, 8'hC0, len, highs, others);
`ifdef PWM_SYNC_UPDATE_EN
    check("t4_chg_high", 32'(highs), 32'd832);
`else
    check("t4_chg_high", 32'(highs), 32'd2496);
`endif
    measure(-1, 8'h00, len, highs, others);
    check("t4_next_high", 32'(highs), 32'd2496);

    // Asynchronous reset while the output is high.
    duty = 8'h80;
    repeat (100) cycle();
    check("t5_pre_high", 32'(out_lo[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_out", 32'({out_hi, out_lo, ps}), 32'h0);
    check("t5_cnt", 32'(dut_a.pwm_cnt_q), 32'h0);
    check("t5_pre", 32'(dut_a.prescaler_q), 32'h0);
    check("t5_b_out", 32'({b_out_hi, b_out_lo, b_ps}), 32'h0);
    repeat (3) cycle();
    rst_n = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!ps && n < 4000);
    check("t5_first_ps", 32'(n), 32'(Period));

    // CLK_DIV = 1 instance, duty 0x03 on channel 15.
    n = 0;
    do begin
      cycle();
      n++;
    end while (!b_ps && n < 300);
    check("t6_ps_seen", 32'(b_ps), 32'd1);
    len   = 0;
    highs = 0;
    n     = 0;
    others = 0;
    do begin
      cycle();
      len++;
      if (b_out_hi[7]) highs++;
      if (b_out_hi[7] && len <= 3) n++;
      if ({b_out_hi[6:0], b_out_lo} != 15'h0) others++;
    end while (!b_ps && len < 300);
    check("t6_len", 32'(len), 32'd256);
    check("t6_high", 32'(highs), 32'd3);
    check("t6_head", 32'(n), 32'd3);
    check("t6_others", 32'(others), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Downstream consumer of the SPI register bank. It turns the five configuration bytes into 16 output channels, each either off, static on, or PWM. A single 8-bit PWM counter, advanced by a prescaler, is shared by all channels, so every channel runs at the same frequency and duty. Outputs drive the chip output pins directly.

Parameters:
CLK_DIV, 13, clk cycles per PWM counter step; legal range >= 1. At 10 MHz clk: 10e6 / (13 * 256) ≈ 3.0 kHz PWM frequency.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en_reg_out_7_0  input  8  output enable, channels 7..0
en_reg_out_15_8  input  8  output enable, channels 15..8
en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0
en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8
pwm_duty_cycle  input  8  duty value; 0x00 = 0 %, 0xFF = 100 %
out_7_0  output  8  channel outputs 7..0, registered
out_15_8  output  8  channel outputs 15..8, registered
period_start  output  1  one-clk pulse at each PWM period start

Behaviour:
- Clock and reset: clock clk; reset rst_n is asynchronous and active-low. All inputs are synchronous to clk and need no synchronizer.
- Reset values: prescaler = 0, pwm_cnt = 0, duty_active = 0x00, out_7_0 = 0x00, out_15_8 = 0x00, period_start = 0.
- Reset mid-operation: all state returns to the reset values immediately. Counting restarts from 0 on the first clk edge after rst_n deasserts.
- Prescaler:
  - Counts 0..CLK_DIV-1.
  - tick = (prescaler == CLK_DIV-1).
  - On tick, prescaler returns to 0; otherwise it increments.
  - With CLK_DIV = 1, tick is asserted every cycle.
  - Prescaler width = $clog2(CLK_DIV), minimum 1 bit.
- PWM counter:
  - 8-bit pwm_cnt increments on tick and wraps 0xFF -> 0x00.
  - Period = 256 * CLK_DIV clk cycles.
- period_start: registered. It is 1 for exactly the one clk cycle that follows the edge where tick && pwm_cnt == 0xFF (the wrap to 0x00).
- Duty shadow:
  - duty_active is loaded from pwm_duty_cycle on the wrap edge (tick && pwm_cnt == 0xFF).
  - Other changes to pwm_duty_cycle are ignored until the next wrap.
  - The feature macro alters this rule.
- PWM compare: pwm_raw = 1 if duty_active == 0xFF, else (pwm_cnt < duty_active). This is combinational, unsigned 8-bit.
  - 0x00 -> pwm_raw never high.
  - 0xFF -> pwm_raw always high (no single-tick dropout).
  - 0x80 -> high for exactly 128 ticks per period.
- Channel select, for channel i in 0..15 (channels 15..8 map to the _15_8 regs bit i-8):
  - en_out[i] = 0 -> 0, regardless of en_pwm[i].
  - en_out[i] = 1, en_pwm[i] = 0 -> 1 (static high).
  - en_out[i] = 1, en_pwm[i] = 1 -> pwm_raw.
- Output register: out_* are registered from the select logic.
  - Latency from an enable-input change to out_* is 1 clk.
  - Latency from a pwm_cnt change to out_* is 1 clk.
- Simultaneous events:
  - A duty input change on the wrap edge itself is captured (the new value applies to the new period).
  - Enable changes take effect at the next clk edge, with no wait for a period boundary.
- No handshake with upstream. Inputs are level registers held stable by the SPI block between writes.

Optional Feature:
PWM_SYNC_UPDATE_EN
- Defined: duty_active is double-buffered exactly as in Behaviour, so updates are glitch-free and only take effect at a period boundary.
- Undefined: duty_active is loaded from pwm_duty_cycle on every clk edge. The new duty affects the compare on the next cycle, mid-period; a runt or stretched pulse in that period is accepted.
- period_start is present in both builds.

Test Plan:
1. CLK_DIV = 13, duty = 0x80, en_out_7_0 = 0x01, en_pwm_7_0 = 0x01 -> out_7_0[0] high 1664 clk, low 1664 clk. period_start pulses every 3328 clk; all other outputs stay 0.
2. Duty 0x00, then 0xFF, each held one full period, channel 0 in PWM mode -> out_7_0[0] constant 0, then constant 1, with no dropout cycle at the 0xFF -> 0x00 wrap.
3. en_out_15_8 = 0xA5, en_pwm_15_8 = 0x00, en_out_7_0 = 0x00, en_pwm_7_0 = 0xFF -> out_15_8 = 0xA5 one clk after the inputs apply; out_7_0 = 0x00 throughout.
4. With PWM_SYNC_UPDATE_EN, duty 0x40 -> 0xC0 at pwm_cnt = 0x10 -> the current period keeps its 64-tick high time; the next period has 192 ticks high. Without the macro -> the high time extends in the same period.
5. Assert rst_n low for 3 clk mid-period while outputs are high, duty 0x80 -> outputs, period_start and counters are 0 immediately. After release, the first period_start appears 3328 clk later.
6. CLK_DIV = 1 build, duty = 0x03, channel 15 enabled in PWM mode -> out_15_8[7] high 3 clk, low 253 clk, repeating every 256 clk.
